// File: rtl/megarom_spi_pkg.sv
// Frame layout, link-check pattern and FSM encoding for the MegaROM CPLD SPI link.
package megarom_spi_pkg;

  localparam int FRAME_BITS  = 32;
  localparam int ADDR_BITS   = 19;
  localparam int RNW_BIT     = 19;
  localparam int WDATA_FIRST = 20;
  localparam int RDATA_FIRST = 24;

  localparam logic [FRAME_BITS-1:0] LINK_MASK    = 32'h7FFFE000;
  localparam logic [FRAME_BITS-1:0] LINK_PATTERN = 32'h55554000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

  // Frame bit n (transmit order) lives at word position FRAME_BITS-1-n.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic                 rnw,
                                                        input logic [ADDR_BITS-1:0] addr,
                                                        input logic [7:0]           wdata,
                                                        input logic                 rel);
    logic [FRAME_BITS-1:0] f;
    f = '0;
    f[FRAME_BITS-1 -: ADDR_BITS] = addr;
    f[FRAME_BITS-1-RNW_BIT]      = rnw;
    if (!rnw) f[FRAME_BITS-1-WDATA_FIRST -: 8] = wdata;
    f[0] = rel;
    return f;
  endfunction

endpackage

// File: rtl/megarom_spi_sck_gen.sv
// SCK divider: one tick every CLK_DIV cycles while run, toggling SCK when toggle_en.
// Latency: rise/fall strobes coincide with the clk edge that changes cpld_SCK.
// Backpressure: none; SCK is forced low whenever toggle_en drops.
module megarom_spi_sck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic nRST,
  input  logic run,
  input  logic toggle_en,
  output logic tick,
  output logic rise,
  output logic fall,
  output logic cpld_SCK
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_cnt;

  assign tick = run && (div_cnt == DW'(CLK_DIV - 1));
  assign rise = tick && toggle_en && !cpld_SCK;
  assign fall = tick && toggle_en && cpld_SCK;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      div_cnt  <= '0;
      cpld_SCK <= 1'b0;
    end else begin
      if (!run || tick) div_cnt <= '0;
      else              div_cnt <= div_cnt + 1'b1;
      cpld_SCK <= toggle_en && (cpld_SCK ^ tick);
    end
  end

endmodule

// File: rtl/megarom_spi_initiator.sv
// SPI mode-0 master: one host request -> one 32-bit SS-framed CPLD transaction (optional MISO_LINK_CHECK_EN).
// Latency: accept -> rsp_valid = 1 + 66*CLK_DIV clk; ready again CLK_DIV*SS_GAP clk later.
// Backpressure: req_ready only in IDLE; requests held during a frame or the SS gap wait.
module megarom_spi_initiator
  import megarom_spi_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int SS_GAP  = 4
) (
  input  logic                 clk,
  input  logic                 nRST,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_rnw,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [7:0]           req_wdata,
  input  logic                 req_release,
  output logic                 rsp_valid,
  output logic [7:0]           rsp_rdata,
  output logic                 busy,
  output logic                 cpld_SCK,
  output logic                 cpld_MOSI,
  output logic                 cpld_SS,
  input  logic                 cpld_MISO
`ifdef MISO_LINK_CHECK_EN
  ,
  output logic                 link_err
`endif
);

  localparam int GW = $clog2(SS_GAP + 1);

  state_t                state;
  logic [FRAME_BITS-1:0] shreg;
  logic [5:0]            hp;
  logic [GW-1:0]         gap_cnt;
  logic                  rnw_q;
  logic [7:0]            rd_sr;
  logic                  accept;
  logic                  run;
  logic                  toggle_en;
  logic                  tick;
  logic                  rise;
  logic                  fall;
  logic [4:0]            rise_bit;

  assign accept = req_valid && req_ready;
  // First SETUP cycle only drops SS; the divider starts on the next one.
  assign run       = (state != ST_IDLE) && !(state == ST_SETUP && cpld_SS);
  assign toggle_en = (state == ST_SETUP && !cpld_SS) || (state == ST_SHIFT && hp != 6'd63);
  // hp counts half-periods of SHIFT; an odd hp ends in the rise of the next bit.
  assign rise_bit  = (state == ST_SHIFT) ? hp[5:1] + 5'd1 : 5'd0;

  megarom_spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk      (clk),
    .nRST     (nRST),
    .run      (run),
    .toggle_en(toggle_en),
    .tick     (tick),
    .rise     (rise),
    .fall     (fall),
    .cpld_SCK (cpld_SCK)
  );

`ifdef MISO_LINK_CHECK_EN
  logic [4:0] link_pos;
  assign link_pos = 5'd31 - rise_bit;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST)        link_err <= 1'b0;
    else if (accept)  link_err <= 1'b0;
    else if (rise && LINK_MASK[link_pos] && (cpld_MISO != LINK_PATTERN[link_pos]))
      link_err <= 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state     <= ST_IDLE;
      req_ready <= 1'b0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      cpld_SS   <= 1'b1;
      cpld_MOSI <= 1'b0;
      shreg     <= '0;
      hp        <= '0;
      gap_cnt   <= '0;
      rnw_q     <= 1'b0;
      rd_sr     <= 8'h00;
    end else begin
      rsp_valid <= 1'b0;
      if (rise && rise_bit >= 5'(RDATA_FIRST)) rd_sr <= {rd_sr[6:0], cpld_MISO};
      case (state)
        ST_IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            shreg     <= build_frame(req_rnw, req_addr, req_wdata, req_release);
            rnw_q     <= req_rnw;
            state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cpld_SS) begin
            cpld_SS   <= 1'b0;
            cpld_MOSI <= shreg[FRAME_BITS-1];
          end else if (tick) begin
            hp    <= '0;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (tick) begin
            if (hp == 6'd63) state <= ST_HOLD;
            else             hp    <= hp + 6'd1;
          end
          if (fall) begin
            shreg     <= shreg << 1;
            cpld_MOSI <= shreg[FRAME_BITS-2];
          end
        end
        ST_HOLD: begin
          if (tick) begin
            cpld_SS   <= 1'b1;
            cpld_MOSI <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= rnw_q ? rd_sr : 8'h00;
            gap_cnt   <= '0;
            state     <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (tick) begin
            if (gap_cnt == GW'(SS_GAP - 1)) begin
              state     <= ST_IDLE;
              req_ready <= 1'b1;
              busy      <= 1'b0;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_megarom_spi_initiator.sv
// Bench for megarom_spi_initiator: three instances (CLK_DIV 1/2/3) each with a behavioural CPLD responder.
module tb_megarom_spi_initiator;

  logic        clk = 1'b0;
  logic        nrst;
  logic [2:0]  req_valid;
  logic        req_rnw;
  logic [18:0] req_addr;
  logic [7:0]  req_wdata;
  logic        req_release;
  logic [7:0]  model_rd;
  int          force_bit;

  logic [2:0]  rdy_v, rsp_v, busy_v, ss_v, sck_v, mosi_v;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic pat(input int b, input logic [7:0] rd, input int fb);
    if (b == fb)                return 1'b0;
    if (b >= 1 && b <= 18)      return b[0];
    if (b >= 24 && b <= 31)     return rd[31-b];
    return 1'b0;
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g
    logic        ready, rv, bz, ss, sck, mosi;
    logic [7:0]  rd;
    logic        miso      = 1'b0;
    logic        prev_sck  = 1'b0;
    logic        prev_ss   = 1'b1;
    logic        prev_mosi = 1'b0;
    logic [31:0] cap       = 32'h0;
    int          cnt       = 0;
    int          stab      = 0;
    int          rspn      = 0;
`ifdef MISO_LINK_CHECK_EN
    logic        lerr;
`endif

    megarom_spi_initiator #(.CLK_DIV(k + 1), .SS_GAP(4)) dut (
      .clk        (clk),
      .nRST       (nrst),
      .req_valid  (req_valid[k]),
      .req_ready  (ready),
      .req_rnw    (req_rnw),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_release(req_release),
      .rsp_valid  (rv),
      .rsp_rdata  (rd),
      .busy       (bz),
      .cpld_SCK   (sck),
      .cpld_MOSI  (mosi),
      .cpld_SS    (ss),
      .cpld_MISO  (miso)
`ifdef MISO_LINK_CHECK_EN
      ,
      .link_err   (lerr)
`endif
    );

    assign rdy_v[k]  = ready;
    assign rsp_v[k]  = rv;
    assign busy_v[k] = bz;
    assign ss_v[k]   = ss;
    assign sck_v[k]  = sck;
    assign mosi_v[k] = mosi;

    // CPLD responder: samples MOSI on SCK rise, drives MISO after SCK fall.
    always @(negedge clk) begin
      if (!ss && prev_ss) begin
        cnt  = 0;
        cap  = 32'h0;
        miso = pat(0, model_rd, force_bit);
      end
      if (!ss && sck && !prev_sck) begin
        cap = {cap[30:0], mosi};
        cnt = cnt + 1;
      end
      if (!ss && !sck && prev_sck) miso = pat(cnt, model_rd, force_bit);
      if (!ss && sck && (mosi != prev_mosi)) stab = stab + 1;
      if (rv) rspn = rspn + 1;
      prev_sck  = sck;
      prev_ss   = ss;
      prev_mosi = mosi;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input int k, input logic rnw, input logic [18:0] a, input logic [7:0] d,
                      input logic rel, output int lat);
    int n;
    n = 0;
    while (!rdy_v[k] && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    check("req_ready_before_send", rdy_v[k], 1'b1);
    req_rnw     = rnw;
    req_addr    = a;
    req_wdata   = d;
    req_release = rel;
    req_valid[k] = 1'b1;
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!rsp_v[k] && lat < 1000);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n, viol, gap, run, seen, base;
    logic [31:0] first_cap;

    nrst = 1'b0; req_valid = 3'b000; req_rnw = 1'b0; req_addr = '0; req_wdata = '0;
    req_release = 1'b0; model_rd = 8'h00; force_bit = -1;

    repeat (3) @(posedge clk);
    #1;
    check("reset_ss",    ss_v,   3'b111);
    check("reset_sck",   sck_v,  3'b000);
    check("reset_mosi",  mosi_v, 3'b000);
    check("reset_ready", rdy_v,  3'b000);
    check("reset_rsp",   rsp_v,  3'b000);
    check("reset_busy",  busy_v, 3'b000);
    check("reset_rdata", g[1].rd, 8'h00);
    @(negedge clk); nrst = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", rdy_v, 3'b111);

    // Write, CLK_DIV=2
    base = g[1].rspn;
    send(1, 1'b0, 19'h12345, 8'hA5, 1'b0, lat);
    check("wr_latency_div2", lat, 133);
    check("wr_busy_at_rsp", busy_v[1], 1'b1);
    check("wr_ss_high_at_rsp", ss_v[1], 1'b1);
    check("wr_frame", g[1].cap, 32'h2468AA50);
    check("wr_rdata_zero", g[1].rd, 8'h00);
    repeat (7) @(posedge clk);
    #1;
    check("gap_ready_low", rdy_v[1], 1'b0);
    check("gap_ss_high", ss_v[1], 1'b1);
    check("wr_single_rsp", g[1].rspn - base, 1);
    @(posedge clk); #1;
    check("gap_ready_back", rdy_v[1], 1'b1);
    check("gap_busy_clear", busy_v[1], 1'b0);
`ifdef MISO_LINK_CHECK_EN
    check("link_err_clean", g[1].lerr, 1'b0);
`endif

    // Read, CLK_DIV=2
    model_rd = 8'h3C;
    send(1, 1'b1, 19'h7FFFF, 8'hEE, 1'b1, lat);
    check("rd_latency_div2", lat, 133);
    check("rd_frame", g[1].cap, 32'hFFFFF001);
    check("rd_rdata", g[1].rd, 8'h3C);
    @(posedge clk); #1;
    check("rsp_is_pulse", rsp_v[1], 1'b0);
    check("rd_rdata_held", g[1].rd, 8'h3C);

    // CLK_DIV=1 write, CLK_DIV=3 read
    send(0, 1'b0, 19'h55555, 8'h0F, 1'b1, lat);
    check("wr_latency_div1", lat, 67);
    check("wr_frame_div1", g[0].cap, 32'hAAAAA0F1);
    model_rd = 8'hC3;
    send(2, 1'b1, 19'h00000, 8'h99, 1'b0, lat);
    check("rd_latency_div3", lat, 199);
    check("rd_frame_div3", g[2].cap, 32'h00001000);
    check("rd_rdata_div3", g[2].rd, 8'hC3);

    // Back-to-back with req_valid held high; fields change mid-frame
    n = 0;
    while (!rdy_v[1] && n < 100) begin @(posedge clk); #1; n++; end
    req_rnw = 1'b0; req_addr = 19'h00001; req_wdata = 8'h11; req_release = 1'b0;
    req_valid[1] = 1'b1;
    n = 0; viol = 0; gap = 0; run = 0; seen = 0; first_cap = 32'h0;
    while (seen < 2 && n < 800) begin
      @(posedge clk); #1; n++;
      if (n == 5) begin req_addr = 19'h40002; req_wdata = 8'h22; end
      if (rdy_v[1] && busy_v[1]) viol++;
      if (rsp_v[1]) begin
        seen++;
        if (seen == 1) first_cap = g[1].cap;
      end
      if (seen == 1) begin
        if (ss_v[1]) run++;
        else if (gap == 0) gap = run;
      end
    end
    req_valid[1] = 1'b0;
    check("b2b_two_frames", seen, 2);
    check("b2b_ready_while_busy", viol, 0);
    check("b2b_ss_gap_cycles", gap, 10);
    check("b2b_first_frame", first_cap, 32'h00002110);
    check("b2b_second_frame", g[1].cap, 32'h80004220);

    // Reset mid-frame at bit 10
    n = 0;
    while (!rdy_v[1] && n < 100) begin @(posedge clk); #1; n++; end
    req_rnw = 1'b0; req_addr = 19'h7AAAA; req_wdata = 8'hFF; req_release = 1'b1;
    req_valid[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    n = 0;
    while (g[1].cnt < 11 && n < 200) begin @(posedge clk); #1; n++; end
    check("abort_reached_bit10", g[1].cnt >= 11, 1'b1);
    nrst = 1'b0;
    #1;
    check("abort_ss_high", ss_v[1], 1'b1);
    check("abort_sck_low", sck_v[1], 1'b0);
    check("abort_busy_low", busy_v[1], 1'b0);
    @(negedge clk); nrst = 1'b1;
    @(posedge clk); #1;
    send(1, 1'b0, 19'h0ABCD, 8'h3C, 1'b1, lat);
    check("post_abort_latency", lat, 133);
    check("post_abort_frame", g[1].cap, 32'h1579A3C1);

    check("mosi_stable_div1", g[0].stab, 0);
    check("mosi_stable_div2", g[1].stab, 0);
    check("mosi_stable_div3", g[2].stab, 0);

`ifdef MISO_LINK_CHECK_EN
    force_bit = 5;
    send(1, 1'b0, 19'h01234, 8'h5A, 1'b0, lat);
    check("link_err_set", g[1].lerr, 1'b1);
    force_bit = -1;
    send(1, 1'b0, 19'h01234, 8'h5A, 1'b0, lat);
    check("link_err_cleared", g[1].lerr, 1'b0);
`endif

    repeat (10) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
